wb_resp_fifo: RTL and testbench
===============================

WB_RESP_FIFO -- requirements
Module: wb_resp_fifo

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0, range 0-15: extra cycles inserted between stb_i sampled and ack_o.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, power of two 2-8: depth of the DATA receive FIFO.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port cyc_i, input, 1 bit: Wishbone bus cycle valid.
REQ-006 SHALL have port stb_i, input, 1 bit: Wishbone strobe.
REQ-007 SHALL have port we_i, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port adr_i, input, 2 bits: register select (0 CTRL, 1 DATA, 2 STATUS, 3 SCRATCH).
REQ-009 SHALL have port dat_i, input, 8 bits: write data.
REQ-010 SHALL have port dat_o, output, 8 bits: read data, valid only while ack_o=1, 0x00 otherwise.
REQ-011 SHALL have port ack_o, output, 1 bit: transfer acknowledge, one-cycle pulse.
REQ-012 SHALL have port irq_o, output, 1 bit: interrupt, level.

Function
REQ-013 SHALL implement FSM IDLE -> WAIT -> ACK -> IDLE; IDLE goes to WAIT when cyc_i&stb_i=1 and WAIT_STATES>0, directly to ACK when WAIT_STATES=0.
REQ-014 SHALL latch adr_i, we_i, dat_i in the IDLE cycle that accepts the request.
REQ-015 SHALL count exactly WAIT_STATES cycles in WAIT, then enter ACK.
REQ-016 SHALL drive ack_o=1 for exactly one cycle, in ACK only; from ACK SHALL always return to IDLE, so back-to-back transfers take WAIT_STATES+2 cycles minimum.
REQ-017 SHALL abort to IDLE with no register/FIFO side effect and no ack_o if cyc_i or stb_i drops while in WAIT.
REQ-018 SHALL commit all side effects (register write, FIFO push/pop, sticky clears) on the ACK cycle only.
REQ-019 CTRL (rw): bit0 irq_en, bit7 fifo_flush (write 1 empties FIFO in the ACK cycle, reads back 0); bits6:1 rw storage.
REQ-020 DATA write SHALL push dat_i when not full; when full SHALL drop data and set sticky overflow.
REQ-021 DATA read SHALL return and pop the head entry; when empty SHALL return 0x00, not change pointers, set sticky underflow.
REQ-022 STATUS (read) SHALL be {overflow, underflow, 0, full, empty, count[2:0]}; count = entries, 0..FIFO_DEPTH (FIFO_DEPTH=8 reports count 0 when full; full bit disambiguates).
REQ-023 STATUS write SHALL clear bit7/bit6 where dat_i bit is 1 (W1C); other bits ignore writes.
REQ-024 SCRATCH SHALL be plain 8-bit rw.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count never exceeds FIFO_DEPTH nor goes below 0.
REQ-026 flush and a DATA access cannot coincide (one transfer per ACK); flush SHALL not clear sticky bits.
REQ-027 irq_o SHALL be registered: irq_en & (!empty | overflow), updated the cycle after the causing ACK.

Reset
REQ-028 On rst_n_i=0 SHALL asynchronously force FSM IDLE, wait counter 0, ack_o 0, dat_o 0x00, irq_o 0, CTRL 0x00, SCRATCH 0x00, FIFO empty, sticky bits 0 (STATUS reads 0x08).
REQ-029 Reset asserted mid-transfer SHALL cancel it with no ack_o; first request after deassertion is accepted normally.

Verification
REQ-030 WAIT_STATES=0: write SCRATCH 0xA5, read SCRATCH -> dat_o=0xA5, ack_o high 1 cycle each, 2 cycles per transfer.
REQ-031 WAIT_STATES=3: read STATUS after reset -> ack_o exactly 4 cycles after stb_i sampled, dat_o=0x08.
REQ-032 Push 0x11,0x22,0x33,0x44,0x55 to DATA (depth 4) -> STATUS=0x94; reads return 0x11..0x44; 5th read returns 0x00, STATUS=0xC8.
REQ-033 CTRL=0x01, push 0x7E -> irq_o=1 next cycle; pop -> irq_o=0; write STATUS 0xC0 clears sticky bits.
REQ-034 WAIT_STATES=5: drop stb_i in WAIT cycle 2 on write SCRATCH 0xFF -> no ack_o, SCRATCH stays 0x00.
REQ-035 Assert rst_n_i mid-WAIT with 3 FIFO entries -> ack_o never pulses, STATUS=0x08, irq_o=0.

Source files
------------

// File: rtl/wb_resp_fifo.sv
// Wishbone slave with CTRL/DATA/STATUS/SCRATCH registers and a small receive FIFO behind DATA.
// Side effects commit only in the single ACK cycle; optional wait states precede it.
module wb_resp_fifo #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [1:0] adr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  output logic       irq_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [3:0] WaitLast = 4'(WAIT_STATES) - 4'd1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  localparam logic [1:0] AdrCtrl    = 2'd0;
  localparam logic [1:0] AdrData    = 2'd1;
  localparam logic [1:0] AdrStatus  = 2'd2;
  localparam logic [1:0] AdrScratch = 2'd3;

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [1:0]      adr_q, adr_d;
  logic            we_q, we_d;
  logic [7:0]      wdat_q, wdat_d;
  logic [6:0]      ctrl_q, ctrl_d;
  logic [7:0]      scratch_q, scratch_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            irq_q, irq_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];

  logic       fifo_empty, fifo_full;
  logic [2:0] cnt_lo;
  logic [7:0] status_rd;
  logic [7:0] rdata;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DepthCnt);
  // Depth 8 full wraps to 0 here; the full bit tells the two apart.
  assign cnt_lo     = 3'(count_q);
  assign status_rd  = {ovf_q, udf_q, 1'b0, fifo_full, fifo_empty, cnt_lo};

  // Bus handshake FSM; request fields are captured when IDLE accepts.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    case (state_q)
      StIdle: begin
        if (cyc_i && stb_i) begin
          adr_d   = adr_i;
          we_d    = we_i;
          wdat_d  = dat_i;
          wcnt_d  = 4'd0;
          state_d = (WAIT_STATES == 0) ? StAck : StWait;
        end
      end
      StWait: begin
        if (!(cyc_i && stb_i)) begin
          state_d = StIdle;
        end else if (wcnt_q == WaitLast) begin
          state_d = StAck;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Register file and FIFO; everything below only changes in the ACK cycle.
  always_comb begin
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mem_d     = mem_q;
    rdata     = 8'h00;
    if (state_q == StAck) begin
      case (adr_q)
        AdrCtrl: begin
          if (we_q) begin
            ctrl_d = wdat_q[6:0];
            if (wdat_q[7]) begin
              wr_ptr_d = '0;
              rd_ptr_d = '0;
              count_d  = '0;
            end
          end else begin
            rdata = {1'b0, ctrl_q};
          end
        end
        AdrData: begin
          if (we_q) begin
            if (fifo_full) begin
              ovf_d = 1'b1;
            end else begin
              mem_d[wr_ptr_q] = wdat_q;
              wr_ptr_d        = wr_ptr_q + 1'b1;
              count_d         = count_q + 1'b1;
            end
          end else if (fifo_empty) begin
            udf_d = 1'b1;
          end else begin
            rdata    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
          end
        end
        AdrStatus: begin
          if (we_q) begin
            if (wdat_q[7]) ovf_d = 1'b0;
            if (wdat_q[6]) udf_d = 1'b0;
          end else begin
            rdata = status_rd;
          end
        end
        AdrScratch: begin
          if (we_q) scratch_d = wdat_q;
          else      rdata     = scratch_q;
        end
        default: rdata = 8'h00;
      endcase
    end
    // Computed from next-state values so irq_o moves on the edge that commits the ACK.
    irq_d = ctrl_d[0] & ((count_d != '0) | ovf_d);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      wcnt_q    <= 4'd0;
      adr_q     <= 2'd0;
      we_q      <= 1'b0;
      wdat_q    <= 8'h00;
      ctrl_q    <= 7'h00;
      scratch_q <= 8'h00;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      irq_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      mem_q     <= '{default: 8'h00};
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      wdat_q    <= wdat_d;
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      irq_q     <= irq_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

  assign ack_o = (state_q == StAck);
  assign dat_o = (ack_o && !we_q) ? rdata : 8'h00;
  assign irq_o = irq_q;

endmodule

// File: tb/tb_wb_resp_fifo.sv
// Directed bench for wb_resp_fifo: three instances (0, 3 and 5 wait states) share the bus fields,
// each with its own cyc/stb; read data is checked against a queue of expected bytes.
module tb_wb_resp_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cyc [3];
  logic       stb [3];
  logic       we;
  logic [1:0] adr;
  logic [7:0] wdat;
  logic       ack [3];
  logic [7:0] rdat [3];
  logic       irq [3];

  int ws [3] = '{0, 3, 5};
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  wb_resp_fifo #(.WAIT_STATES(0), .FIFO_DEPTH(4)) u_ws0 (
    .clk_i(clk), .rst_n_i(rst_n), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we), .adr_i(adr),
    .dat_i(wdat), .dat_o(rdat[0]), .ack_o(ack[0]), .irq_o(irq[0])
  );
  wb_resp_fifo #(.WAIT_STATES(3), .FIFO_DEPTH(4)) u_ws3 (
    .clk_i(clk), .rst_n_i(rst_n), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we), .adr_i(adr),
    .dat_i(wdat), .dat_o(rdat[1]), .ack_o(ack[1]), .irq_o(irq[1])
  );
  wb_resp_fifo #(.WAIT_STATES(5), .FIFO_DEPTH(4)) u_ws5 (
    .clk_i(clk), .rst_n_i(rst_n), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we), .adr_i(adr),
    .dat_i(wdat), .dat_o(rdat[2]), .ack_o(ack[2]), .irq_o(irq[2])
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, expv);
    end
  endtask

  // One Wishbone transfer on instance d; reads push their expected byte before driving.
  task automatic xfer(input int d, input logic w, input logic [1:0] a, input logic [7:0] wd,
                      input logic [7:0] exp_rd, input string tag);
    int n;
    bit seen;
    logic [7:0] expv;
    if (!w) exp_q.push_back(exp_rd);
    we = w; adr = a; wdat = wd;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ack[d]) seen = 1'b1;
    end
    check({tag, "_ack"}, 8'(seen), 8'd1);
    check({tag, "_lat"}, 8'(n), 8'(ws[d] + 1));
    if (!w) begin
      expv = exp_q.pop_front();
      check({tag, "_rd"}, rdat[d], expv);
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(posedge clk); #1;
    check({tag, "_pulse"}, 8'(ack[d]), 8'd0);
  endtask

  initial begin
    bit any_ack;
    rst_n = 1'b0; we = 1'b0; adr = 2'd0; wdat = 8'h00;
    for (int i = 0; i < 3; i++) begin cyc[i] = 1'b0; stb[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ack%0d", i), 8'(ack[i]), 8'd0);
      check($sformatf("rst_dat%0d", i), rdat[i], 8'h00);
      check($sformatf("rst_irq%0d", i), 8'(irq[i]), 8'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three wait states: STATUS after reset
    xfer(1, 1'b0, 2'd2, 8'h00, 8'h08, "ws3_status");

    // Zero wait states: SCRATCH round trip
    xfer(0, 1'b1, 2'd3, 8'hA5, 8'h00, "scr_wr");
    xfer(0, 1'b0, 2'd3, 8'h00, 8'hA5, "scr_rd");

    // Overfill a depth-4 FIFO, drain it, then underflow
    xfer(0, 1'b1, 2'd1, 8'h11, 8'h00, "push1");
    xfer(0, 1'b1, 2'd1, 8'h22, 8'h00, "push2");
    xfer(0, 1'b1, 2'd1, 8'h33, 8'h00, "push3");
    xfer(0, 1'b1, 2'd1, 8'h44, 8'h00, "push4");
    xfer(0, 1'b1, 2'd1, 8'h55, 8'h00, "push5");
    xfer(0, 1'b0, 2'd2, 8'h00, 8'h94, "st_full");
    xfer(0, 1'b0, 2'd1, 8'h00, 8'h11, "pop1");
    xfer(0, 1'b0, 2'd1, 8'h00, 8'h22, "pop2");
    xfer(0, 1'b0, 2'd1, 8'h00, 8'h33, "pop3");
    xfer(0, 1'b0, 2'd1, 8'h00, 8'h44, "pop4");
    xfer(0, 1'b0, 2'd1, 8'h00, 8'h00, "pop_empty");
    xfer(0, 1'b0, 2'd2, 8'h00, 8'hC8, "st_sticky");

    // Sticky clear, interrupt, flush
    xfer(0, 1'b1, 2'd2, 8'hC0, 8'h00, "w1c");
    xfer(0, 1'b0, 2'd2, 8'h00, 8'h08, "st_clr");
    xfer(0, 1'b1, 2'd0, 8'h01, 8'h00, "irq_en");
    check("irq_idle", 8'(irq[0]), 8'd0);
    xfer(0, 1'b1, 2'd1, 8'h7E, 8'h00, "push_7e");
    check("irq_set", 8'(irq[0]), 8'd1);
    xfer(0, 1'b0, 2'd1, 8'h00, 8'h7E, "pop_7e");
    check("irq_clr", 8'(irq[0]), 8'd0);
    xfer(0, 1'b1, 2'd1, 8'hAA, 8'h00, "pushA");
    xfer(0, 1'b1, 2'd1, 8'hBB, 8'h00, "pushB");
    xfer(0, 1'b0, 2'd2, 8'h00, 8'h02, "st_two");
    xfer(0, 1'b1, 2'd0, 8'h81, 8'h00, "flush");
    xfer(0, 1'b0, 2'd2, 8'h00, 8'h08, "st_flushed");
    xfer(0, 1'b0, 2'd0, 8'h00, 8'h01, "ctrl_rd");
    check("irq_flush", 8'(irq[0]), 8'd0);

    // Five wait states: strobe dropped in the second WAIT cycle aborts the write
    we = 1'b1; adr = 2'd3; wdat = 8'hFF;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    any_ack = 1'b0;
    @(posedge clk); #1;
    any_ack |= ack[2];
    @(posedge clk); #1;
    any_ack |= ack[2];
    stb[2] = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      any_ack |= ack[2];
    end
    cyc[2] = 1'b0;
    check("abort_noack", 8'(any_ack), 8'd0);
    xfer(2, 1'b0, 2'd3, 8'h00, 8'h00, "abort_scr");

    // Reset in the middle of a waited transfer with three entries queued
    xfer(1, 1'b1, 2'd0, 8'h01, 8'h00, "r_irq_en");
    xfer(1, 1'b1, 2'd1, 8'h01, 8'h00, "r_push1");
    xfer(1, 1'b1, 2'd1, 8'h02, 8'h00, "r_push2");
    xfer(1, 1'b1, 2'd1, 8'h03, 8'h00, "r_push3");
    check("r_irq_pre", 8'(irq[1]), 8'd1);
    xfer(1, 1'b0, 2'd2, 8'h00, 8'h03, "r_st3");
    we = 1'b0; adr = 2'd2;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    any_ack = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      any_ack |= ack[1];
    end
    rst_n = 1'b0;
    #1;
    check("r_irq_async", 8'(irq[1]), 8'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      any_ack |= ack[1];
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      any_ack |= ack[1];
    end
    check("r_noack", 8'(any_ack), 8'd0);
    check("r_irq_post", 8'(irq[1]), 8'd0);
    xfer(1, 1'b0, 2'd2, 8'h00, 8'h08, "r_st_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
